// File: rtl/ins_mem_loader_pkg.sv
// Shared definitions for the instruction memory loader: default widths,
// the loader state encoding and the bytes-per-instruction helper.
// Pure declarations; no latency or backpressure of its own.
package ins_mem_loader_pkg;

    localparam int PC_INS_ADDR_W_DEF = 8;
    localparam int INS_DATA_W_DEF    = 60;
    localparam int BYTE_W_DEF        = 8;

    // Number of host bytes needed to cover one instruction word (rounded up).
    function automatic int bytes_per_ins(input int data_w, input int byte_w);
        return (data_w + byte_w - 1) / byte_w;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_WRITE   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RUN     = 3'd4
    } ldr_state_t;

endpackage

// File: rtl/ins_mem_loader_word_packer.sv
// Packs a little-endian byte stream into one instruction word; byte k lands at bits [k*BYTE_W +: BYTE_W].
// Latency: a byte is visible on word_out the cycle after byte_en; word_full flags the last byte combinationally.
// Backpressure: none inside; the caller only asserts byte_en when it can take the byte.
// Ports: clk, reset (sync, active high), clr (restart at byte 0), byte_en/byte_in (store one byte),
//        word_out (assembled word), word_full (the byte taken this cycle completes the word).
module ins_word_packer
    import ins_mem_loader_pkg::*;
#(
    parameter int INS_DATA_W = INS_DATA_W_DEF,
    parameter int BYTE_W     = BYTE_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  byte_en,
    input  logic [BYTE_W-1:0]     byte_in,
    output logic [INS_DATA_W-1:0] word_out,
    output logic                  word_full
);

    localparam int BYTES_PER_INS = bytes_per_ins(INS_DATA_W, BYTE_W);
    localparam int IDX_W         = (BYTES_PER_INS > 1) ? $clog2(BYTES_PER_INS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_INS - 1);

    logic [IDX_W-1:0] idx_q;

    assign word_full = byte_en && (idx_q == LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q <= '0;
        end else if (clr) begin
            idx_q <= '0;
        end else if (byte_en) begin
            idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // One register per byte lane. The top lane is trimmed to the bits that
    // fall inside the word, so host bits beyond INS_DATA_W are never stored.
    for (genvar k = 0; k < BYTES_PER_INS; k++) begin : g_lane
        localparam int LO = k * BYTE_W;
        localparam int HI = (((LO + BYTE_W) < INS_DATA_W) ? (LO + BYTE_W) : INS_DATA_W) - 1;
        localparam int LW = HI - LO + 1;

        logic [LW-1:0] lane_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                lane_q <= '0;
            end else if (byte_en && (idx_q == IDX_W'(k))) begin
                lane_q <= byte_in[LW-1:0];
            end
        end

        assign word_out[HI:LO] = lane_q;
    end

endmodule

// File: rtl/ins_mem_loader.sv
// Loads host bytes into the vertex processor instruction memory from address 0, then resets and enables the processor.
// Latency: each word is written 1 cycle after its last byte; proc_reset follows the final write by 1 cycle, RUN by 2.
// Backpressure: in_ready is high only while collecting bytes; it drops for the single write cycle after each word.
// Ports: clk, reset (sync, active high); start/ins_count/abort load control; in_valid/in_data/in_ready host byte stream;
//        we_ins_m/addr_ins_m/din_ins_m instruction memory write port; proc_reset/proc_enable processor control;
//        busy/done/err status (done and err are 1-cycle pulses, registered).
module ins_mem_loader
    import ins_mem_loader_pkg::*;
#(
    parameter int PC_INS_ADDR_W = PC_INS_ADDR_W_DEF,
    parameter int INS_DATA_W    = INS_DATA_W_DEF,
    parameter int BYTE_W        = BYTE_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [PC_INS_ADDR_W:0]   ins_count,
    input  logic                     abort,
    input  logic                     in_valid,
    input  logic [BYTE_W-1:0]        in_data,
    output logic                     in_ready,
    output logic                     we_ins_m,
    output logic [PC_INS_ADDR_W-1:0] addr_ins_m,
    output logic [INS_DATA_W-1:0]    din_ins_m,
    output logic                     proc_reset,
    output logic                     proc_enable,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    // Full memory depth is the largest legal count; it needs the extra count bit.
    localparam logic [PC_INS_ADDR_W:0] MAX_COUNT = (PC_INS_ADDR_W + 1)'(1) << PC_INS_ADDR_W;

    ldr_state_t state_q, state_d;

    logic [PC_INS_ADDR_W:0]   count_q;
    logic [PC_INS_ADDR_W-1:0] addr_q;
    logic [PC_INS_ADDR_W-1:0] addr_hold_q;
    logic [INS_DATA_W-1:0]    din_hold_q;
    logic [INS_DATA_W-1:0]    word;
    logic                     word_full;
    logic                     err_q;
    logic                     done_q;

    logic count_legal;
    logic can_start;
    logic in_busy;
    logic start_ok;
    logic last_ins;
    logic byte_en;
    logic pack_clr;

    assign count_legal = (ins_count != '0) && (ins_count <= MAX_COUNT);
    assign can_start   = (state_q == ST_IDLE) || (state_q == ST_RUN);
    assign in_busy     = (state_q == ST_COLLECT) || (state_q == ST_WRITE) || (state_q == ST_RELEASE);
    assign start_ok    = start && !abort && can_start && count_legal;
    // Comparing against count-1 keeps the address inside 0..2**W-1, so a
    // full-depth load ends at the top address instead of wrapping to 0.
    assign last_ins    = ({1'b0, addr_q} == (count_q - (PC_INS_ADDR_W + 1)'(1)));
    assign byte_en     = in_valid && in_ready;
    // The packer restarts at byte 0 for every new load and after every write.
    assign pack_clr    = start_ok || (state_q == ST_WRITE);

    ins_word_packer #(
        .INS_DATA_W (INS_DATA_W),
        .BYTE_W     (BYTE_W)
    ) u_packer (
        .clk       (clk),
        .reset     (reset),
        .clr       (pack_clr),
        .byte_en   (byte_en),
        .byte_in   (in_data),
        .word_out  (word),
        .word_full (word_full)
    );

    always_comb begin
        state_d     = state_q;
        in_ready    = 1'b0;
        we_ins_m    = 1'b0;
        proc_reset  = 1'b0;
        proc_enable = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_ok) state_d = ST_COLLECT;
            end
            ST_COLLECT: begin
                in_ready = 1'b1;
                if (word_full) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                we_ins_m = 1'b1;
                state_d  = last_ins ? ST_RELEASE : ST_COLLECT;
            end
            ST_RELEASE: begin
                proc_reset = 1'b1;
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                proc_enable = 1'b1;
                if (start_ok) state_d = ST_COLLECT;
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) state_d = ST_IDLE;
    end

    // Outside the write cycle the port shows the last written address/data.
    assign addr_ins_m = we_ins_m ? addr_q : addr_hold_q;
    assign din_ins_m  = we_ins_m ? word   : din_hold_q;
    assign busy       = in_busy;
    assign done       = done_q;
    assign err        = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            addr_q      <= '0;
            addr_hold_q <= '0;
            din_hold_q  <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= start && !abort && (in_busy || !count_legal);
            done_q  <= (state_q == ST_RELEASE) && !abort;

            if (start_ok) begin
                count_q <= ins_count;
                addr_q  <= '0;
            end else if ((state_q == ST_WRITE) && !last_ins && !abort) begin
                addr_q <= addr_q + PC_INS_ADDR_W'(1);
            end

            if (state_q == ST_WRITE) begin
                addr_hold_q <= addr_q;
                din_hold_q  <= word;
            end
        end
    end

endmodule

// File: tb/tb_ins_mem_loader.sv
// Directed-plus-random bench for the instruction memory loader.
// Expected words are rebuilt from the byte stream with plain arithmetic.
// A negedge monitor records writes, handshakes and status pulses.
module tb_ins_mem_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [8:0]  ins_count;
    logic        abort;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        we_ins_m;
    logic [7:0]  addr_ins_m;
    logic [59:0] din_ins_m;
    logic        proc_reset;
    logic        proc_enable;
    logic        busy;
    logic        done;
    logic        err;

    ins_mem_loader dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ins_count   (ins_count),
        .abort       (abort),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .we_ins_m    (we_ins_m),
        .addr_ins_m  (addr_ins_m),
        .din_ins_m   (din_ins_m),
        .proc_reset  (proc_reset),
        .proc_enable (proc_enable),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    int          cyc = 0;
    logic [7:0]  stim[$];
    logic [7:0]  wr_addr[$];
    logic [59:0] wr_data[$];
    int          wr_cyc[$];
    int          hs_cyc[$];
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          preset_cyc = -1;
    int          pe_rise_cyc = -1;
    logic        pe_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (we_ins_m) begin
            wr_addr.push_back(addr_ins_m);
            wr_data.push_back(din_ins_m);
            wr_cyc.push_back(cyc);
        end
        if (in_valid && in_ready) hs_cyc.push_back(cyc);
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (proc_reset) preset_cyc = cyc;
        if (proc_enable && !pe_prev) pe_rise_cyc = cyc;
        pe_prev = proc_enable;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Little-endian assembly of 8 bytes; anything above bit 59 is dropped.
    function automatic logic [59:0] model_word(input int first);
        logic [63:0] w;
        w = '0;
        for (int k = 0; k < 8; k++) w = w | (64'(stim[first + k]) << (8 * k));
        return w[59:0];
    endfunction

    task automatic fill_random(input int n);
        stim.delete();
        for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
    endtask

    // Entered and left at posedge+1.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int cnt, input logic with_abort);
        start     = 1'b1;
        ins_count = 9'(cnt);
        abort     = with_abort;
        step();
        start = 1'b0;
        abort = 1'b0;
    endtask

    // Present stim[from..to-1], holding each byte until in_ready takes it.
    task automatic feed(input string tag, input int from, input int to, input int gap_pct);
        int   stuck;
        logic acc;
        stuck = 0;
        for (int i = from; i < to; i++) begin
            while (int'($urandom_range(0, 99)) < gap_pct) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                step();
            end
            in_valid = 1'b1;
            in_data  = stim[i];
            acc = 1'b0;
            for (int g = 0; g < 50 && !acc; g++) begin
                @(negedge clk);
                acc = in_ready;
                step();
            end
            if (!acc) stuck++;
        end
        in_valid = 1'b0;
        chk({tag, " feed stalled"}, 64'(stuck), 64'd0);
    endtask

    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 4000 && !seen; n++) begin
            @(negedge clk);
            seen = done;
        end
        step();
        chk({tag, " done seen"}, 64'(seen), 64'd1);
    endtask

    task automatic check_writes(input string tag, input int wbase, input int n, input int sbase);
        chk({tag, " write count"}, 64'(wr_addr.size() - wbase), 64'(n));
        for (int j = 0; j < n; j++) begin
            if (wbase + j < wr_addr.size()) begin
                chk($sformatf("%s addr[%0d]", tag, j), 64'(wr_addr[wbase + j]), 64'(j));
                chk($sformatf("%s din[%0d]", tag, j), 64'(wr_data[wbase + j]), 64'(model_word(sbase + 8 * j)));
            end
        end
    endtask

    initial begin
        int wb, hb, db, eb, t2b;

        reset     = 1'b1;
        start     = 1'b0;
        ins_count = '0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;

        // ---- reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset ctl", 64'({in_ready, we_ins_m, proc_reset, proc_enable, busy, done, err}), 64'd0);
        chk("reset addr", 64'(addr_ins_m), 64'd0);
        chk("reset din", 64'(din_ins_m), 64'd0);
        step();
        reset = 1'b0;
        step();

        // ---- T1: one instruction, bytes 00..07
        stim.delete();
        for (int i = 0; i < 8; i++) stim.push_back(8'(i));
        wb = wr_addr.size(); hb = hs_cyc.size(); db = done_cnt;
        do_start(1, 1'b0);
        feed("t1", 0, 8, 0);
        wait_done("t1");
        check_writes("t1", wb, 1, 0);
        if (wr_addr.size() > wb) begin
            chk("t1 din const", 64'(wr_data[wb]), 64'h0706_0504_0302_0100);
            chk("t1 write after last byte", 64'(wr_cyc[wb] - hs_cyc[hb + 7]), 64'd1);
            chk("t1 proc_reset after write", 64'(preset_cyc - wr_cyc[wb]), 64'd1);
            chk("t1 proc_enable after write", 64'(pe_rise_cyc - wr_cyc[wb]), 64'd2);
        end
        chk("t1 done pulses", 64'(done_cnt - db), 64'd1);
        chk("t1 run state", 64'({proc_enable, busy}), 64'b10);

        // ---- T2: three instructions, continuous valid
        fill_random(24);
        wb = wr_addr.size(); hb = hs_cyc.size(); t2b = wb;
        do_start(3, 1'b0);
        feed("t2", 0, 24, 0);
        wait_done("t2");
        check_writes("t2", wb, 3, 0);
        chk("t2 handshakes", 64'(hs_cyc.size() - hb), 64'd24);
        if (hs_cyc.size() >= hb + 24) begin
            chk("t2 back-to-back bytes", 64'(hs_cyc[hb + 1] - hs_cyc[hb]), 64'd1);
            chk("t2 ready gap word0", 64'(hs_cyc[hb + 8] - hs_cyc[hb + 7]), 64'd2);
            chk("t2 ready gap word1", 64'(hs_cyc[hb + 16] - hs_cyc[hb + 15]), 64'd2);
        end

        // ---- T4: same bytes with random valid gaps -> same words
        wb = wr_addr.size();
        do_start(3, 1'b0);
        feed("t4", 0, 24, 40);
        wait_done("t4");
        check_writes("t4", wb, 3, 0);
        for (int j = 0; j < 3; j++) begin
            if (wb + j < wr_data.size())
                chk($sformatf("t4 equals gapless[%0d]", j), 64'(wr_data[wb + j]), 64'(wr_data[t2b + j]));
        end

        // ---- T3: full depth, 256 instructions
        fill_random(256 * 8);
        wb = wr_addr.size(); db = done_cnt;
        do_start(256, 1'b0);
        feed("t3", 0, 256 * 8, 0);
        wait_done("t3");
        repeat (20) step();
        check_writes("t3", wb, 256, 0);
        if (wr_addr.size() > wb) chk("t3 last addr", 64'(wr_addr[wr_addr.size() - 1]), 64'd255);
        chk("t3 done once", 64'(done_cnt - db), 64'd1);

        // ---- T5: abort after byte 5 of word 2, then reload
        fill_random(24);
        wb = wr_addr.size();
        do_start(3, 1'b0);
        feed("t5", 0, 21, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        @(negedge clk);
        chk("t5 idle after abort", 64'({busy, in_ready, we_ins_m, proc_enable}), 64'd0);
        step();
        repeat (20) step();
        chk("t5 writes before abort", 64'(wr_addr.size() - wb), 64'd2);
        fill_random(16);
        wb = wr_addr.size();
        do_start(2, 1'b0);
        feed("t5 reload", 0, 16, 20);
        wait_done("t5 reload");
        check_writes("t5 reload", wb, 2, 0);

        // ---- T6: illegal counts in RUN, start while busy, abort+start
        wb = wr_addr.size(); eb = err_cnt;
        do_start(0, 1'b0);
        @(negedge clk);
        chk("t6 err count0", 64'(err), 64'd1);
        chk("t6 count0 stays run", 64'({proc_enable, busy}), 64'b10);
        step();
        do_start(257, 1'b0);
        @(negedge clk);
        chk("t6 err count257", 64'(err), 64'd1);
        chk("t6 count257 stays run", 64'({proc_enable, busy}), 64'b10);
        step();
        chk("t6 no writes", 64'(wr_addr.size() - wb), 64'd0);

        fill_random(16);
        do_start(2, 1'b0);
        feed("t6", 0, 3, 0);
        do_start(1, 1'b0);
        @(negedge clk);
        chk("t6 err busy start", 64'(err), 64'd1);
        chk("t6 still collecting", 64'({busy, in_ready, proc_enable}), 64'b110);
        step();
        feed("t6", 3, 16, 0);
        wait_done("t6");
        check_writes("t6", wb, 2, 0);
        chk("t6 err pulses", 64'(err_cnt - eb), 64'd3);

        eb = err_cnt;
        do_start(2, 1'b1);
        @(negedge clk);
        chk("t6 abort beats start", 64'({busy, proc_enable, in_ready}), 64'd0);
        step();
        chk("t6 abort no err", 64'(err_cnt - eb), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
